// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller in front of the combinational ALU.
// Accepts one op per valid/ready handshake, holds the registered operands on the
// ALU for a per-opcode number of cycles, then captures the 64-bit result into Z.
// Optional feature: define SEQ_DIV0_TRAP_EN to trap DIV by zero without sequencing it.
module alu_sequencer #(
  parameter int unsigned ALU_CYCLES    = 1,
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [63:0] alu_out,
  input  logic        alu_zero,
  output logic [31:0] z_hi,
  output logic [31:0] z_lo,
  output logic        z_zero,
  output logic        done,
  output logic        busy,
  output logic        err
);

  localparam logic [3:0]  OpMul     = 4'b0111;
  localparam logic [3:0]  OpDiv     = 4'b1010;
  localparam int unsigned MaxCycles = (ALU_CYCLES > MULDIV_CYCLES) ? ALU_CYCLES : MULDIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic {StIdle, StHold} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            accept;
  logic            is_muldiv;
  logic [CntW-1:0] cnt_load;

  // Handshake and status decode; ready is forced low while clear is asserted.
  assign req_ready = ~clear & (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign accept    = req_valid & req_ready;
  assign is_muldiv = (req_op == OpMul) || (req_op == OpDiv);
  // Counter holds remaining hold cycles minus one; capture happens when it reads zero.
  assign cnt_load  = is_muldiv ? CntW'(MULDIV_CYCLES - 1) : CntW'(ALU_CYCLES - 1);

`ifdef SEQ_DIV0_TRAP_EN
  logic div0;
  logic err_q;
  assign div0 = (req_op == OpDiv) && (req_b == 32'h0);
  assign err  = err_q;
`else
  assign err  = 1'b0;
`endif

  // Sequencer FSM with registered ALU operands, Z capture and done/err pulses.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= '0;
      z_hi     <= '0;
      z_lo     <= '0;
      z_zero   <= 1'b0;
      done     <= 1'b0;
`ifdef SEQ_DIV0_TRAP_EN
      err_q    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SEQ_DIV0_TRAP_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (accept) begin
            alu_a    <= req_a;
            alu_b    <= req_b;
            alu_ctrl <= req_op;
`ifdef SEQ_DIV0_TRAP_EN
            if (div0) begin
              // Trapped divide: report immediately, Z keeps its previous value.
              done  <= 1'b1;
              err_q <= 1'b1;
            end else begin
              cnt_q   <= cnt_load;
              state_q <= StHold;
            end
`else
            cnt_q   <= cnt_load;
            state_q <= StHold;
`endif
          end
        end
        StHold: begin
          if (cnt_q == '0) begin
            z_hi    <= alu_out[63:32];
            z_lo    <= alu_out[31:0];
            z_zero  <= alu_zero;
            done    <= 1'b1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
